// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: npc_op encodings, fetch address constants and FSM state codes.
package fetch_pc_unit_pkg;
   typedef enum logic [2:0] {
      NPC_SEQ = 3'd0,
      NPC_BR  = 3'd1,
      NPC_J   = 3'd2,
      NPC_JR  = 3'd3
   } npc_op_e;
   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
   localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
   localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;
   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_EXC  = 2'd2;
endpackage

// File: rtl/fetch_pc_unit_npc.sv
// npc_calc: combinational next-PC target selection from the D-stage control kind.
module npc_calc
   import fetch_pc_unit_pkg::*;
(
   input  logic [2:0]  npc_op_i,
   input  logic        cmp_out_i,
   input  logic [31:0] f_pc_i,
   input  logic [31:0] d_pc_i,
   input  logic [25:0] d_imm26_i,
   input  logic [31:0] d_rs_val_i,
   output logic [31:0] npc_o,
   output logic        ctrl_o
);
   logic [31:0] seq, br, j;
   assign seq = f_pc_i + 32'd4;
   assign br = d_pc_i + 32'd4 + {{14{d_imm26_i[15]}}, d_imm26_i[15:0], 2'b00};
   assign j = {d_pc_i[31:28], d_imm26_i, 2'b00};
   // undefined encodings fall through to sequential fetch
   assign npc_o = npc_op_i == NPC_BR ? (cmp_out_i ? br : seq) :
                  npc_op_i == NPC_J  ? j :
                  npc_op_i == NPC_JR ? d_rs_val_i : seq;
   assign ctrl_o = npc_op_i == NPC_BR || npc_op_i == NPC_J || npc_op_i == NPC_JR;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register, BOOT/RUN/EXC_ENTRY FSM and delay-slot tracking.
// Define IFU_ADEL_CHECK_EN to build the fetch address error range check.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [2:0]  npc_op,
   input  logic        cmp_out,
   input  logic [31:0] d_pc,
   input  logic [25:0] d_imm26,
   input  logic [31:0] d_rs_val,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] f_pc,
   output logic        f_valid,
   output logic        f_bd,
   output logic        d_bd,
   output logic        f_adel,
   output logic        d_flush
);
   logic [1:0] state_q, state_d;
   logic [31:0] pc_q, pc_d, npc;
   logic d_bd_q, d_bd_d, ctrl;
   npc_calc u_npc (
      .npc_op_i   (npc_op),
      .cmp_out_i  (cmp_out),
      .f_pc_i     (pc_q),
      .d_pc_i     (d_pc),
      .d_imm26_i  (d_imm26),
      .d_rs_val_i (d_rs_val),
      .npc_o      (npc),
      .ctrl_o     (ctrl)
   );
   always_comb begin
      state_d = state_q == ST_BOOT ? ST_RUN : exc_req ? ST_EXC : ST_RUN;
      pc_d = exc_req ? PC_HANDLER : eret ? epc : stall ? pc_q : npc;
      d_bd_d = (exc_req | eret) ? 1'b0 : stall ? d_bd_q : f_bd;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q <= PC_RESET;
         d_bd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         d_bd_q <= d_bd_d;
      end
   end
   assign f_pc = pc_q;
   assign f_valid = state_q != ST_BOOT;
   assign f_bd = state_q == ST_RUN && ctrl;
   assign d_bd = d_bd_q;
   assign d_flush = exc_req | eret;
`ifdef IFU_ADEL_CHECK_EN
   assign f_adel = f_valid & ((pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI));
`else
   assign f_adel = 1'b0;
`endif
endmodule
